// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: keeps the fixed-latency program memory busy and queues returned words with their PCs.
// Optional IFU_BYPASS_EN: a return arriving at an empty queue is presented combinationally in the same cycle.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          MEM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        fetch_en_in,
  output logic [31:0] mem_addr_out,
  output logic        mem_read_request_out,
  input  logic [31:0] mem_instr_in,
  input  logic        mem_data_valid_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  input  logic        ready_in
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int SW = CW + 2;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   q_instr_q [QUEUE_DEPTH];
  logic [31:0]   q_instr_d [QUEUE_DEPTH];
  logic [31:0]   q_pc_q [QUEUE_DEPTH];
  logic [31:0]   q_pc_d [QUEUE_DEPTH];
  logic [31:0]   pc_sr_q [MEM_LATENCY];
  logic [31:0]   pc_sr_d [MEM_LATENCY];

  logic          ret, keep, push, q_pop, issue;
  logic [SW-1:0] credit;
`ifdef IFU_BYPASS_EN
  logic          bypass;
`endif

  // Returns are only honoured while something is outstanding, so stray strobes after reset are ignored.
  always_comb begin
    ret    = mem_data_valid_in && ((inflight_q != '0) || (discard_q != '0));
    keep   = ret && (discard_q == '0) && !redirect_in;
    q_pop  = ready_in && (count_q != '0);
`ifdef IFU_BYPASS_EN
    bypass = keep && (count_q == '0);
    push   = keep && !(bypass && ready_in);
`else
    push   = keep;
`endif
    credit = SW'(count_q) - SW'(q_pop) + SW'(inflight_q) + SW'(discard_q);
    issue  = fetch_en_in && !redirect_in && (credit < SW'(QUEUE_DEPTH));
  end

  // Consumer handshake: the head word transfers on any rising clk_in where valid_out && ready_in;
  // valid_out never depends on ready_in, and the head stays stable until it transfers or a redirect flushes it.
  always_comb begin
    instr_out = q_instr_q[rd_q];
    pc_out    = q_pc_q[rd_q];
    valid_out = (count_q != '0);
`ifdef IFU_BYPASS_EN
    if (bypass) begin
      instr_out = mem_instr_in;
      pc_out    = pc_sr_q[MEM_LATENCY-1];
      valid_out = 1'b1;
    end
`endif
  end

  assign mem_addr_out         = addr_q;
  assign mem_read_request_out = req_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = issue;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    q_instr_d  = q_instr_q;
    q_pc_d     = q_pc_q;
    pc_sr_d[0] = addr_q;
    for (int i = 1; i < MEM_LATENCY; i++) pc_sr_d[i] = pc_sr_q[i-1];

    if (issue) begin
      addr_d     = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
      inflight_d = inflight_q + CW'(1);
    end
    // Discarded words are always older than live ones, so drain the discard count first.
    if (ret) begin
      if (discard_q != '0) discard_d  = discard_q - CW'(1);
      else                 inflight_d = inflight_d - CW'(1);
    end
    if (push) begin
      q_instr_d[wr_q] = mem_instr_in;
      q_pc_d[wr_q]    = pc_sr_q[MEM_LATENCY-1];
      wr_d            = wr_q + PW'(1);
    end
    if (q_pop) rd_d = rd_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(q_pop);

    // Everything still outstanding after this cycle belongs to the old stream.
    if (redirect_in) begin
      fetch_pc_d = redirect_pc_in & 32'hFFFF_FFFC;
      discard_d  = discard_q + inflight_q - CW'(ret);
      inflight_d = '0;
      count_d    = '0;
      rd_d       = wr_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
      for (int i = 0; i < MEM_LATENCY; i++) pc_sr_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      q_instr_q  <= q_instr_d;
      q_pc_q     <= q_pc_d;
      pc_sr_q    <= pc_sr_d;
    end
  end

endmodule
